rv32i_decode_exec: RTL and testbench
====================================

Name: rv32i_decode_exec

Overview:
Combinational decode/execute core for the single-cycle RV32I CPU. It decodes the fetched instruction and computes the ALU result (a data address, branch target or write-back value) from PC, immediate and register operands. It resolves the next-PC selection and drives register-file, data-memory and write-back-select controls. One registered element, a sticky halted flag, is the only clocked state.

Parameters:
RESET_HALTED, 0, value loaded into halted on reset.

Ports:
clk  in  1  system clock.
rst  in  1  reset, asynchronous, active-low.
en  in  1  global enable; gates the halted update.
inst  in  32  current instruction.
pc  in  32  current PC.
rf_rd0  in  32  register-file value of rs1.
rf_rd1  in  32  register-file value of rs2.
rf_ra0  out  5  rs1 index, inst[19:15].
rf_ra1  out  5  rs2 index, inst[24:20].
rf_wa  out  5  rd index, inst[11:7].
rf_we  out  1  register write enable.
rf_wd_sel  out  2  write-back select: 0 = pc+4, 1 = alu_res, 2 = load data.
imm  out  32  sign-extended immediate.
alu_res  out  32  ALU result.
npc_sel  out  2  next-PC select: 0 = pc+4, 1 = alu_res, 2 = alu_res & ~1.
dmem_we  out  1  store enable.
dmem_access  out  4  load/store size code.
halt  out  1  inst == 0x00100073 (ebreak), combinational.
halted  out  1  sticky halt flag, registered.

Behaviour:
- Decode, ALU and branch paths are purely combinational, with zero latency.
- alu_op codes: ADD 0, SUB 2, SLT 4, SLTU 5, AND 9, OR 10, XOR 11, SLL 14, SRL 15, SRA 16, SRC0 17, SRC1 18. Any other code produces 0.
- ALU input 0 is rf_rd0, or pc for auipc/jal/branches.
- ALU input 1 is rf_rd1 for R-type, otherwise imm.
- ALU arithmetic: 32-bit wrap-around. SLT compares signed, SLTU unsigned. Shift amount is src1[4:0]. SRA is arithmetic.
- Immediates: I, S, B, U and J formats per RV32I, all sign-extended. U-type is imm = {inst[31:12], 12'b0}.
- Per-class control:
  - lui: SRC1, wd_sel 1.
  - auipc: ADD pc+imm, wd_sel 1.
  - OP/OP-IMM: funct3/funct7 map to ALU ops; inst[30] selects SUB/SRA. wd_sel 1.
  - loads: ADD, wd_sel 2, rf_we 1.
  - stores: ADD, dmem_we 1, rf_we 0.
  - branches: ADD pc+imm, rf_we 0.
  - jal: ADD pc+imm, wd_sel 0, rf_we 1.
  - jalr: ADD rs1+imm, wd_sel 0, rf_we 1.
- dmem_access codes: 0 none, LB 1, LH 2, LW 3, LBU 4, LHU 5, SB 6, SH 7, SW 8.
- rf_we follows the opcode even when rd = x0; the register file ignores writes to x0.
- br_type codes (internal): NONE 0, BEQ 1, BNE 2, BLT 3, BGE 4, BLTU 5, BGEU 6, JAL 7, JALR 8.
- npc_sel: 1 for JAL or a taken branch, 2 for JALR, 0 otherwise. Branch comparison uses rf_rd0 vs rf_rd1, signed for BLT/BGE and unsigned for BLTU/BGEU.
- Unknown opcode, ebreak, and all-zero instruction act as NOP: rf_we 0, dmem_we 0, dmem_access 0, npc_sel 0, imm 0.
- halted:
  - rst low asynchronously sets halted = RESET_HALTED.
  - On posedge clk with en = 1 and halt = 1, halted is set to 1.
  - Once set, halted stays 1 until reset; en = 0 holds its value.
  - Reset mid-operation clears it immediately, regardless of clk.

Decomposition:
- Shared package: opcode constants, ALU op codes, br_type codes, dmem_access codes, npc_sel and rf_wd_sel encodings, and HALT_INST = 0x00100073.
- One sub-module, alu_core: (src0, src1, op) -> res. Decoder, immediate generation and branch resolution stay in the top level.

Test Plan:
- addi x1,x0,5 (0x00500093), rf_rd0 = 0 -> rf_we 1, rf_wa 1, imm 5, alu_res 5, rf_wd_sel 1, npc_sel 0.
- beq x1,x2,+8 (0x00208463), pc 0x00400000, rd0 = rd1 = 7 -> alu_res 0x00400008, npc_sel 1. With rd1 = 8 -> npc_sel 0, rf_we 0.
- jalr x1,0(x5) (0x000280E7), rd0 = 0x00400011 -> alu_res 0x00400011, npc_sel 2, rf_wd_sel 0, rf_we 1.
- sw x2,4(x1) (0x0020A223), rd0 = 0x100 -> alu_res 0x104, dmem_we 1, dmem_access 8, rf_we 0.
- sra x3,x1,x2 (0x4020D1B3), rd0 = 0x80000000, rd1 = 4 -> alu_res 0xF8000000. sltu with rd0 = 0xFFFFFFFF, rd1 = 1 -> 0.
- ebreak 0x00100073 -> halt 1. With en = 1, halted becomes 1 after the edge and stays 1 after inst changes. Driving rst low between edges clears halted at once.

Source files
------------

// File: rtl/rv32i_decode_exec_pkg.sv
// Shared definitions for the RV32I decode/execute slice.
// Holds opcode constants, ALU operation codes, branch-type codes, data-memory
// access size codes, next-PC and write-back select encodings, the ebreak
// encoding, and small helpers for immediate extraction and ALU-op mapping.
package rv32i_decode_exec_pkg;

    // Major opcodes (inst[6:0]) recognised by the decoder
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ALU operation codes; any other code yields a zero result
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd4;
    localparam logic [4:0] ALU_SLTU = 5'd5;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_OR   = 5'd10;
    localparam logic [4:0] ALU_XOR  = 5'd11;
    localparam logic [4:0] ALU_SLL  = 5'd14;
    localparam logic [4:0] ALU_SRL  = 5'd15;
    localparam logic [4:0] ALU_SRA  = 5'd16;
    localparam logic [4:0] ALU_SRC0 = 5'd17;
    localparam logic [4:0] ALU_SRC1 = 5'd18;

    // Branch / jump classification used for next-PC resolution
    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_BEQ  = 4'd1,
        BR_BNE  = 4'd2,
        BR_BLT  = 4'd3,
        BR_BGE  = 4'd4,
        BR_BLTU = 4'd5,
        BR_BGEU = 4'd6,
        BR_JAL  = 4'd7,
        BR_JALR = 4'd8
    } br_type_e;

    // Data-memory access size codes
    localparam logic [3:0] ACC_NONE = 4'd0;
    localparam logic [3:0] ACC_LB   = 4'd1;
    localparam logic [3:0] ACC_LH   = 4'd2;
    localparam logic [3:0] ACC_LW   = 4'd3;
    localparam logic [3:0] ACC_LBU  = 4'd4;
    localparam logic [3:0] ACC_LHU  = 4'd5;
    localparam logic [3:0] ACC_SB   = 4'd6;
    localparam logic [3:0] ACC_SH   = 4'd7;
    localparam logic [3:0] ACC_SW   = 4'd8;

    // Next-PC select encodings
    localparam logic [1:0] NPC_PC4        = 2'd0;
    localparam logic [1:0] NPC_ALU        = 2'd1;
    localparam logic [1:0] NPC_ALU_ALIGN  = 2'd2;

    // Register write-back select encodings
    localparam logic [1:0] WD_PC4  = 2'd0;
    localparam logic [1:0] WD_ALU  = 2'd1;
    localparam logic [1:0] WD_MEM  = 2'd2;

    localparam logic [31:0] HALT_INST = 32'h0010_0073;

    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:25], inst[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] inst);
        return {inst[31:12], 12'h000};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // funct3 -> ALU op; alt selects SUB/SRA and is pre-qualified by the caller
    function automatic logic [4:0] alu_op_decode(input logic [2:0] funct3, input logic alt);
        logic [4:0] op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_decode_exec_alu_core.sv
// Combinational 32-bit ALU.
// Ports:
//   src0 - operand 0 (register rs1 or PC)
//   src1 - operand 1 (register rs2 or immediate); src1[4:0] is the shift amount
//   op   - operation code from rv32i_decode_exec_pkg; unknown codes give 0
//   res  - result
module alu_core
    import rv32i_decode_exec_pkg::*;
(
    input  logic [31:0] src0,
    input  logic [31:0] src1,
    input  logic [4:0]  op,
    output logic [31:0] res
);

    logic [4:0] shamt_s;

    assign shamt_s = src1[4:0];

    // Operation select; arithmetic wraps at 32 bits
    always_comb begin
        res = 32'd0;
        case (op)
            ALU_ADD:  res = src0 + src1;
            ALU_SUB:  res = src0 - src1;
            ALU_SLT:  res = {31'd0, ($signed(src0) < $signed(src1))};
            ALU_SLTU: res = {31'd0, (src0 < src1)};
            ALU_AND:  res = src0 & src1;
            ALU_OR:   res = src0 | src1;
            ALU_XOR:  res = src0 ^ src1;
            ALU_SLL:  res = src0 << shamt_s;
            ALU_SRL:  res = src0 >> shamt_s;
            ALU_SRA:  res = $unsigned($signed(src0) >>> shamt_s);
            ALU_SRC0: res = src0;
            ALU_SRC1: res = src1;
            default:  res = 32'd0;
        endcase
    end

endmodule

// File: rtl/rv32i_decode_exec.sv
// Decode/execute stage of the single-cycle RV32I CPU.
// Decodes inst, generates the immediate, computes the ALU result, resolves
// the next-PC selection and drives register-file / data-memory controls.
// The sticky halted flag is the only clocked state.
// Ports:
//   clk, rst (async active-low), en (gates the halted update)
//   inst, pc, rf_rd0, rf_rd1          - instruction, PC and register operands
//   rf_ra0, rf_ra1, rf_wa, rf_we      - register-file addressing and write enable
//   rf_wd_sel                         - write-back source (pc+4 / alu / load)
//   imm, alu_res                      - immediate and ALU result
//   npc_sel                           - next PC (pc+4 / alu / alu & ~1)
//   dmem_we, dmem_access              - store enable and access size code
//   halt, halted                      - ebreak detect and sticky halt flag
module rv32i_decode_exec
    import rv32i_decode_exec_pkg::*;
#(
    parameter logic RESET_HALTED = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    input  logic [31:0] rf_rd0,
    input  logic [31:0] rf_rd1,
    output logic [4:0]  rf_ra0,
    output logic [4:0]  rf_ra1,
    output logic [4:0]  rf_wa,
    output logic        rf_we,
    output logic [1:0]  rf_wd_sel,
    output logic [31:0] imm,
    output logic [31:0] alu_res,
    output logic [1:0]  npc_sel,
    output logic        dmem_we,
    output logic [3:0]  dmem_access,
    output logic        halt,
    output logic        halted
);

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [4:0]  alu_op_s;
    logic        src0_pc_s;
    logic        src1_rf_s;
    logic [31:0] src0_s;
    logic [31:0] src1_s;
    br_type_e    br_type_s;
    logic        taken_s;
    logic        halted_r;

    assign opcode_s = inst[6:0];
    assign funct3_s = inst[14:12];
    assign rf_ra0   = inst[19:15];
    assign rf_ra1   = inst[24:20];
    assign rf_wa    = inst[11:7];
    assign halt     = (inst == HALT_INST);
    assign halted   = halted_r;

    // Main decoder: defaults describe a NOP, each opcode overrides what it uses
    always_comb begin
        alu_op_s    = ALU_ADD;
        src0_pc_s   = 1'b0;
        src1_rf_s   = 1'b0;
        imm         = 32'd0;
        rf_we       = 1'b0;
        rf_wd_sel   = WD_ALU;
        dmem_we     = 1'b0;
        dmem_access = ACC_NONE;
        br_type_s   = BR_NONE;
        case (opcode_s)
            OPC_LUI: begin
                imm      = imm_u(inst);
                alu_op_s = ALU_SRC1;
                rf_we    = 1'b1;
            end
            OPC_AUIPC: begin
                imm       = imm_u(inst);
                src0_pc_s = 1'b1;
                rf_we     = 1'b1;
            end
            OPC_JAL: begin
                imm       = imm_j(inst);
                src0_pc_s = 1'b1;
                rf_we     = 1'b1;
                rf_wd_sel = WD_PC4;
                br_type_s = BR_JAL;
            end
            OPC_JALR: begin
                imm       = imm_i(inst);
                rf_we     = 1'b1;
                rf_wd_sel = WD_PC4;
                br_type_s = BR_JALR;
            end
            OPC_BRANCH: begin
                imm       = imm_b(inst);
                src0_pc_s = 1'b1;
                case (funct3_s)
                    3'b000:  br_type_s = BR_BEQ;
                    3'b001:  br_type_s = BR_BNE;
                    3'b100:  br_type_s = BR_BLT;
                    3'b101:  br_type_s = BR_BGE;
                    3'b110:  br_type_s = BR_BLTU;
                    3'b111:  br_type_s = BR_BGEU;
                    default: br_type_s = BR_NONE;
                endcase
            end
            OPC_LOAD: begin
                imm       = imm_i(inst);
                rf_wd_sel = WD_MEM;
                case (funct3_s)
                    3'b000:  dmem_access = ACC_LB;
                    3'b001:  dmem_access = ACC_LH;
                    3'b010:  dmem_access = ACC_LW;
                    3'b100:  dmem_access = ACC_LBU;
                    3'b101:  dmem_access = ACC_LHU;
                    default: dmem_access = ACC_NONE;
                endcase
                // An undefined load width writes nothing back
                rf_we = (dmem_access != ACC_NONE);
            end
            OPC_STORE: begin
                imm = imm_s(inst);
                case (funct3_s)
                    3'b000:  dmem_access = ACC_SB;
                    3'b001:  dmem_access = ACC_SH;
                    3'b010:  dmem_access = ACC_SW;
                    default: dmem_access = ACC_NONE;
                endcase
                dmem_we = (dmem_access != ACC_NONE);
            end
            OPC_OP_IMM: begin
                imm   = imm_i(inst);
                rf_we = 1'b1;
                // inst[30] is an immediate bit except for shift-right, so only SRAI uses it
                alu_op_s = alu_op_decode(funct3_s, inst[30] & (funct3_s == 3'b101));
            end
            OPC_OP: begin
                src1_rf_s = 1'b1;
                rf_we     = 1'b1;
                alu_op_s  = alu_op_decode(funct3_s, inst[30]);
            end
            default: begin
                alu_op_s = ALU_ADD;
            end
        endcase
    end

    // ALU operand muxing
    always_comb begin
        src0_s = src0_pc_s ? pc : rf_rd0;
        src1_s = src1_rf_s ? rf_rd1 : imm;
    end

    alu_core u_alu_core (
        .src0 (src0_s),
        .src1 (src1_s),
        .op   (alu_op_s),
        .res  (alu_res)
    );

    // Branch condition evaluation on the register operands
    always_comb begin
        taken_s = 1'b0;
        case (br_type_s)
            BR_BEQ:  taken_s = (rf_rd0 == rf_rd1);
            BR_BNE:  taken_s = (rf_rd0 != rf_rd1);
            BR_BLT:  taken_s = ($signed(rf_rd0) <  $signed(rf_rd1));
            BR_BGE:  taken_s = ($signed(rf_rd0) >= $signed(rf_rd1));
            BR_BLTU: taken_s = (rf_rd0 <  rf_rd1);
            BR_BGEU: taken_s = (rf_rd0 >= rf_rd1);
            default: taken_s = 1'b0;
        endcase
    end

    // Next-PC selection; JALR clears bit 0 downstream via the align encoding
    always_comb begin
        npc_sel = NPC_PC4;
        case (br_type_s)
            BR_JAL:  npc_sel = NPC_ALU;
            BR_JALR: npc_sel = NPC_ALU_ALIGN;
            default: npc_sel = taken_s ? NPC_ALU : NPC_PC4;
        endcase
    end

    // Sticky halt flag: set on an enabled ebreak, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted_r <= RESET_HALTED;
        end else if (en && halt) begin
            halted_r <= 1'b1;
        end else begin
            halted_r <= halted_r;
        end
    end

endmodule

// File: tb/tb_rv32i_decode_exec.sv
// Self-checking bench for rv32i_decode_exec: directed cases followed by
// randomized instructions compared against a behavioural reference model.
module tb_rv32i_decode_exec;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rf_rd0;
    logic [31:0] rf_rd1;
    logic [4:0]  rf_ra0;
    logic [4:0]  rf_ra1;
    logic [4:0]  rf_wa;
    logic        rf_we;
    logic [1:0]  rf_wd_sel;
    logic [31:0] imm;
    logic [31:0] alu_res;
    logic [1:0]  npc_sel;
    logic        dmem_we;
    logic [3:0]  dmem_access;
    logic        halt;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    rv32i_decode_exec #(.RESET_HALTED(1'b0)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .inst        (inst),
        .pc          (pc),
        .rf_rd0      (rf_rd0),
        .rf_rd1      (rf_rd1),
        .rf_ra0      (rf_ra0),
        .rf_ra1      (rf_ra1),
        .rf_wa       (rf_wa),
        .rf_we       (rf_we),
        .rf_wd_sel   (rf_wd_sel),
        .imm         (imm),
        .alu_res     (alu_res),
        .npc_sel     (npc_sel),
        .dmem_we     (dmem_we),
        .dmem_access (dmem_access),
        .halt        (halt),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b);
        inst   = i;
        pc     = p;
        rf_rd0 = a;
        rf_rd1 = b;
        #1;
    endtask

    typedef struct {
        logic [31:0] imm;
        logic [31:0] alu;
        logic        rf_we;
        logic        dmem_we;
        logic [1:0]  wd;
        logic [1:0]  npc;
        logic [3:0]  acc;
        bit          chk_alu;
        bit          chk_wd;
    } exp_t;

    // Register/immediate arithmetic by RV32I funct3 meaning
    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] x, input logic [31:0] y);
        int signed sx;
        int signed sy;
        int        sh;
        sx = x;
        sy = y;
        sh = int'(y % 32);
        case (f3)
            3'd0:    return alt ? x - y : x + y;
            3'd1:    return x << sh;
            3'd2:    return (sx < sy) ? 32'd1 : 32'd0;
            3'd3:    return (x < y) ? 32'd1 : 32'd0;
            3'd4:    return x ^ y;
            3'd5:    return alt ? 32'(sx >>> sh) : x >> sh;
            3'd6:    return x | y;
            default: return x & y;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] i, input logic [31:0] p,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [2:0]  f3;
        int signed   ii;
        int signed   is;
        int signed   ib;
        int signed   ij;
        logic [31:0] iu;
        int signed   sa;
        int signed   sb;
        bit          tk;
        f3 = i[14:12];
        ii = int'($signed(i[31:20]));
        is = int'($signed({i[31:25], i[11:7]}));
        ib = int'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        ij = int'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        iu = {i[31:12], 12'h000};
        sa = a;
        sb = b;
        e = '{imm: 32'd0, alu: 32'd0, rf_we: 1'b0, dmem_we: 1'b0, wd: 2'd0,
              npc: 2'd0, acc: 4'd0, chk_alu: 1'b0, chk_wd: 1'b0};
        case (i[6:0])
            7'h37: begin e.imm = iu; e.alu = iu; e.rf_we = 1'b1; e.wd = 2'd1; e.chk_alu = 1'b1; e.chk_wd = 1'b1; end
            7'h17: begin e.imm = iu; e.alu = p + iu; e.rf_we = 1'b1; e.wd = 2'd1; e.chk_alu = 1'b1; e.chk_wd = 1'b1; end
            7'h6F: begin e.imm = ij; e.alu = p + ij; e.rf_we = 1'b1; e.wd = 2'd0; e.npc = 2'd1; e.chk_alu = 1'b1; e.chk_wd = 1'b1; end
            7'h67: begin e.imm = ii; e.alu = a + ii; e.rf_we = 1'b1; e.wd = 2'd0; e.npc = 2'd2; e.chk_alu = 1'b1; e.chk_wd = 1'b1; end
            7'h63: begin
                e.imm = ib; e.alu = p + ib; e.chk_alu = 1'b1;
                case (f3)
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = (sa < sb);
                    3'd5: tk = (sa >= sb);
                    3'd6: tk = (a < b);
                    3'd7: tk = (a >= b);
                    default: tk = 1'b0;
                endcase
                e.npc = tk ? 2'd1 : 2'd0;
            end
            7'h03: begin
                e.imm = ii; e.alu = a + ii; e.rf_we = 1'b1; e.wd = 2'd2; e.chk_alu = 1'b1; e.chk_wd = 1'b1;
                e.acc = (f3 < 3'd3) ? 4'(f3 + 3'd1) : 4'(f3);
            end
            7'h23: begin e.imm = is; e.alu = a + is; e.dmem_we = 1'b1; e.acc = 4'(f3) + 4'd6; e.chk_alu = 1'b1; end
            7'h13: begin
                e.imm = ii; e.rf_we = 1'b1; e.wd = 2'd1; e.chk_alu = 1'b1; e.chk_wd = 1'b1;
                e.alu = ref_alu(f3, i[30] && (f3 == 3'd5), a, ii);
            end
            7'h33: begin
                e.rf_we = 1'b1; e.wd = 2'd1; e.chk_alu = 1'b1; e.chk_wd = 1'b1;
                e.alu = ref_alu(f3, i[30], a, b);
            end
            default: e.chk_alu = 1'b0;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_inst(input int cls);
        logic [31:0] r;
        logic [2:0]  f3;
        logic        alt;
        logic [6:0]  junk [4];
        junk[0] = 7'h00; junk[1] = 7'h7F; junk[2] = 7'h73; junk[3] = 7'h0F;
        r   = $urandom;
        alt = 1'($urandom_range(0, 1));
        f3  = r[14:12];
        case (cls)
            0: r[6:0] = 7'h37;
            1: r[6:0] = 7'h17;
            2: r[6:0] = 7'h6F;
            3: begin r[6:0] = 7'h67; r[14:12] = 3'd0; end
            4: begin
                r[6:0] = 7'h63;
                if (f3 == 3'd2 || f3 == 3'd3) r[14:12] = 3'd0;
            end
            5: begin
                r[6:0] = 7'h03;
                if (f3 == 3'd3 || f3 > 3'd5) r[14:12] = 3'd2;
            end
            6: begin r[6:0] = 7'h23; r[14:12] = 3'($urandom_range(0, 2)); end
            7: begin
                r[6:0] = 7'h13;
                if (f3 == 3'd1) r[31:25] = 7'h00;
                if (f3 == 3'd5) r[31:25] = {1'b0, alt, 5'd0};
            end
            8: begin
                r[6:0]   = 7'h33;
                r[31:25] = (f3 == 3'd0 || f3 == 3'd5) ? {1'b0, alt, 5'd0} : 7'h00;
            end
            default: r[6:0] = junk[$urandom_range(0, 3)];
        endcase
        return r;
    endfunction

    initial begin
        exp_t        e;
        logic [31:0] ri;
        logic [31:0] rp;
        logic [31:0] ra;
        logic [31:0] rb;

        rst = 1'b0; en = 1'b0;
        apply(32'd0, 32'd0, 32'd0, 32'd0);
        #2;
        check("reset_halted", {31'd0, halted}, 32'd0);
        check("zero_inst_halt", {31'd0, halt}, 32'd0);
        check("zero_inst_rf_we", {31'd0, rf_we}, 32'd0);
        check("zero_inst_imm", imm, 32'd0);
        check("zero_inst_npc", {30'd0, npc_sel}, 32'd0);
        check("zero_inst_acc", {28'd0, dmem_access}, 32'd0);
        #10 rst = 1'b1;

        // addi x1,x0,5
        apply(32'h0050_0093, 32'h0040_0000, 32'd0, 32'd0);
        check("addi_rf_we", {31'd0, rf_we}, 32'd1);
        check("addi_rf_wa", {27'd0, rf_wa}, 32'd1);
        check("addi_imm", imm, 32'd5);
        check("addi_alu", alu_res, 32'd5);
        check("addi_wd_sel", {30'd0, rf_wd_sel}, 32'd1);
        check("addi_npc", {30'd0, npc_sel}, 32'd0);

        // beq x1,x2,+8 taken and not taken
        apply(32'h0020_8463, 32'h0040_0000, 32'd7, 32'd7);
        check("beq_alu", alu_res, 32'h0040_0008);
        check("beq_taken_npc", {30'd0, npc_sel}, 32'd1);
        apply(32'h0020_8463, 32'h0040_0000, 32'd7, 32'd8);
        check("beq_nt_npc", {30'd0, npc_sel}, 32'd0);
        check("beq_rf_we", {31'd0, rf_we}, 32'd0);

        // jalr x1,0(x5)
        apply(32'h0002_80E7, 32'h0040_0000, 32'h0040_0011, 32'd0);
        check("jalr_alu", alu_res, 32'h0040_0011);
        check("jalr_npc", {30'd0, npc_sel}, 32'd2);
        check("jalr_wd_sel", {30'd0, rf_wd_sel}, 32'd0);
        check("jalr_rf_we", {31'd0, rf_we}, 32'd1);
        check("jalr_ra0", {27'd0, rf_ra0}, 32'd5);

        // sw x2,4(x1)
        apply(32'h0020_A223, 32'h0040_0000, 32'h0000_0100, 32'd0);
        check("sw_alu", alu_res, 32'h0000_0104);
        check("sw_dmem_we", {31'd0, dmem_we}, 32'd1);
        check("sw_acc", {28'd0, dmem_access}, 32'd8);
        check("sw_rf_we", {31'd0, rf_we}, 32'd0);
        check("sw_ra1", {27'd0, rf_ra1}, 32'd2);

        // sra x3,x1,x2 and sltu x3,x1,x2
        apply(32'h4020_D1B3, 32'h0040_0000, 32'h8000_0000, 32'd4);
        check("sra_alu", alu_res, 32'hF800_0000);
        apply(32'h0020_B1B3, 32'h0040_0000, 32'hFFFF_FFFF, 32'd1);
        check("sltu_alu", alu_res, 32'd0);

        // Randomized instructions against the reference model
        for (int n = 0; n < 400; n++) begin
            ri = rand_inst(int'($urandom_range(0, 9)));
            rp = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
            if ($urandom_range(0, 3) == 0) rb = ra ^ 32'h8000_0000;
            apply(ri, rp, ra, rb);
            e = model(ri, rp, ra, rb);
            check("rnd_imm", imm, e.imm);
            check("rnd_rf_we", {31'd0, rf_we}, {31'd0, e.rf_we});
            check("rnd_dmem_we", {31'd0, dmem_we}, {31'd0, e.dmem_we});
            check("rnd_acc", {28'd0, dmem_access}, {28'd0, e.acc});
            check("rnd_npc", {30'd0, npc_sel}, {30'd0, e.npc});
            check("rnd_ra0", {27'd0, rf_ra0}, {27'd0, ri[19:15]});
            check("rnd_ra1", {27'd0, rf_ra1}, {27'd0, ri[24:20]});
            check("rnd_wa", {27'd0, rf_wa}, {27'd0, ri[11:7]});
            check("rnd_halt", {31'd0, halt}, {31'd0, (ri == 32'h0010_0073)});
            if (e.chk_alu) check("rnd_alu", alu_res, e.alu);
            if (e.chk_wd)  check("rnd_wd_sel", {30'd0, rf_wd_sel}, {30'd0, e.wd});
        end
        check("halted_idle", {31'd0, halted}, 32'd0);

        // Halt flag behaviour
        @(negedge clk);
        en = 1'b0;
        apply(32'h0010_0073, 32'd0, 32'd0, 32'd0);
        check("ebreak_halt", {31'd0, halt}, 32'd1);
        check("ebreak_rf_we", {31'd0, rf_we}, 32'd0);
        @(posedge clk); #1;
        check("halted_en0", {31'd0, halted}, 32'd0);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk); #1;
        check("halted_set", {31'd0, halted}, 32'd1);
        @(negedge clk);
        apply(32'h0050_0093, 32'd0, 32'd0, 32'd0);
        check("addi_no_halt", {31'd0, halt}, 32'd0);
        @(posedge clk); #1;
        check("halted_sticky", {31'd0, halted}, 32'd1);
        en = 1'b0;
        @(posedge clk); #1;
        check("halted_hold", {31'd0, halted}, 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("halted_async_clr", {31'd0, halted}, 32'd0);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("halted_after_rst", {31'd0, halted}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
